// File: rtl/pattern_gen.sv
// Seedable burst pattern source (LFSR / count / walking-one / constant) over valid/ready.
// Optional out_parity output when PATTERN_GEN_PARITY_EN is defined.
`timescale 1ns/1ps
module pattern_gen #(
  parameter int unsigned       WIDTH = 4,
  parameter int unsigned       CNT_W = 8,
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(4'b1110),
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(4'b1100)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] length,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done
`ifdef PATTERN_GEN_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] M_LFSR  = 2'd0;
  localparam logic [1:0] M_COUNT = 2'd1;
  localparam logic [1:0] M_WALK  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] first;
  logic [WIDTH-1:0] nxt;

  // Repair register values that would lock up or break the selected pattern.
  function automatic logic [WIDTH-1:0] sanitize(input logic [1:0] m, input logic [WIDTH-1:0] v);
    logic one_hot;
    one_hot = (v != '0) && ((v & (v - WIDTH'(1))) == '0);
    case (m)
      M_LFSR:  return (v == '0) ? SEED : v;
      M_WALK:  return one_hot ? v : WIDTH'(1);
      default: return v;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [1:0] m, input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] s;
    s = sanitize(m, v);
    case (m)
      M_LFSR:  return {s[WIDTH-2:0], ^(s & TAPS)};
      M_COUNT: return s + WIDTH'(1);
      M_WALK:  return {s[WIDTH-2:0], s[WIDTH-1]};
      default: return s;
    endcase
  endfunction

  assign src   = seed_load ? seed_in : pat_q;
  assign first = sanitize(mode, src);
  assign nxt   = advance(mode_q, pat_q);

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        pat_d = src;
        if (start) begin
          if (length != '0) begin
            pat_d   = first;
            data_d  = first;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            mode_d  = mode;
            rem_d   = length;
            state_d = ST_RUN;
          end else begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (valid_q && out_ready) begin
          pat_d = nxt;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            data_d = nxt;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mode_q  <= M_LFSR;
      pat_q   <= SEED;
      rem_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef PATTERN_GEN_PARITY_EN
  logic parity_q;

  // Parity tracks data_d so it updates and holds exactly with out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= ^data_d;
  end

  assign out_parity = parity_q;
`endif

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Table-driven bench for pattern_gen with an expected-word scoreboard queue.
`timescale 1ns/1ps
module tb_pattern_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [7:0] length;
  logic       seed_load;
  logic [3:0] seed_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       busy;
  logic       done;
`ifdef PATTERN_GEN_PARITY_EN
  logic       out_parity;
`endif

  pattern_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .length(length),
    .seed_load(seed_load), .seed_in(seed_in), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .done(done)
`ifdef PATTERN_GEN_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  len;
    logic        sl;
    logic [3:0]  seed;
    logic [3:0]  rmask;
    logic        poke;
    logic [19:0] exp;
  } row_t;

  row_t       rows [11];
  row_t       row_after_reset;
  logic [3:0] sb [$];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_burst(input row_t r);
    int         beats = 0;
    int         last = -1;
    bit         seen_done = 0;
    bit         stall = 0;
    bit         busy_ok = 1;
    logic [3:0] held = '0;
    logic [3:0] exp_w;
    for (int i = 0; i < int'(r.len); i++) sb.push_back(r.exp[i*4 +: 4]);
    @(posedge clk); #1;
    mode = r.mode; length = r.len; seed_load = r.sl; seed_in = r.seed; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; seed_load = 1'b0;
    for (int cyc = 0; cyc < 64 && !seen_done; cyc++) begin
      out_ready = r.rmask[cyc[1:0]];
      if (r.poke && cyc == 1) begin
        start = 1'b1; length = 8'd9; seed_load = 1'b1; seed_in = 4'h0;
      end
      @(negedge clk);
      if (stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(out_data), 32'(held));
      end
      stall = out_valid && !out_ready;
      held  = out_data;
      if (done) begin
        seen_done = 1;
        check("done_beats", 32'(beats), 32'(r.len));
        check("done_timing", 32'(cyc), 32'(last + 1));
        check("done_busy", 32'(busy), 32'd0);
      end else if (!busy) begin
        busy_ok = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL extra_beat: got data %0h expected no beat at %0t", out_data, $time);
        end else begin
          exp_w = sb.pop_front();
          check("beat_data", 32'(out_data), 32'(exp_w));
`ifdef PATTERN_GEN_PARITY_EN
          check("beat_parity", 32'(out_parity), 32'(^exp_w));
`endif
        end
        beats++;
        last = cyc;
      end
      @(posedge clk); #1;
      start = 1'b0; seed_load = 1'b0;
    end
    check("done_seen", 32'(seen_done), 32'd1);
    check("busy_during_run", 32'(busy_ok), 32'd1);
    check("sb_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_valid", 32'(out_valid), 32'd0);
    sb.delete();
  endtask

  initial begin
    // mode, len, seed_load, seed, ready mask (bit per cycle), start-while-busy poke, words (w0 in low nibble)
    rows[0]  = '{2'd0, 8'd4, 1'b0, 4'h0, 4'hF, 1'b0, 20'h018CE};
    rows[1]  = '{2'd1, 8'd3, 1'b1, 4'hE, 4'hF, 1'b0, 20'h000FE};
    rows[2]  = '{2'd2, 8'd5, 1'b1, 4'h0, 4'hD, 1'b0, 20'h18421};
    rows[3]  = '{2'd0, 8'd4, 1'b1, 4'hE, 4'h9, 1'b0, 20'h018CE};
    rows[4]  = '{2'd0, 8'd0, 1'b0, 4'h0, 4'hF, 1'b0, 20'h00000};
    rows[5]  = '{2'd3, 8'd3, 1'b1, 4'h5, 4'hF, 1'b0, 20'h00555};
    rows[6]  = '{2'd1, 8'd2, 1'b0, 4'h0, 4'hF, 1'b0, 20'h00065};
    rows[7]  = '{2'd0, 8'd2, 1'b1, 4'h0, 4'hF, 1'b0, 20'h000CE};
    rows[8]  = '{2'd2, 8'd2, 1'b1, 4'h6, 4'hF, 1'b0, 20'h00021};
    rows[9]  = '{2'd1, 8'd3, 1'b1, 4'h2, 4'hF, 1'b1, 20'h00432};
    rows[10] = '{2'd1, 8'd2, 1'b0, 4'h0, 4'hF, 1'b0, 20'h00065};
    row_after_reset = '{2'd0, 8'd2, 1'b0, 4'h0, 4'hF, 1'b0, 20'h000CE};

    rst_n = 1'b0; start = 1'b0; mode = 2'd0; length = 8'd0;
    seed_load = 1'b0; seed_in = 4'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
`ifdef PATTERN_GEN_PARITY_EN
    check("rst_parity", 32'(out_parity), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 11; k++) run_burst(rows[k]);

    // Reset in the middle of a long burst.
    @(posedge clk); #1;
    mode = 2'd0; length = 8'd8; seed_load = 1'b1; seed_in = 4'h3; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; seed_load = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2;
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_data", 32'(out_data), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_done", 32'(done), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("reset_no_done", 32'(done), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_burst(row_after_reset);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
